// File: rtl/io_in_fifo.sv
// io_in_fifo: byte FIFO buffering external input strobes for CPU input instructions; overflow flag built only with IO_IN_OVF_EN
module io_in_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ext_strobe,
  input  logic [7:0]    ext_data,
  output logic          ext_full,
  input  logic          cpu_rd,
  output logic [7:0]    cpu_data,
  output logic          cpu_empty,
  output logic [CW-1:0] cpu_count,
  output logic          ovf,
  input  logic          ovf_clr
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_full;
  logic          w_empty;
  // A full buffer still takes a push when the head is popped in the same cycle
  always_comb begin
    w_full  = r_count == CW'(DEPTH);
    w_empty = r_count == '0;
    w_pop   = cpu_rd && !w_empty;
    w_push  = ext_strobe && (!w_full || w_pop);
    w_drop  = ext_strobe && !w_push;
  end
  // Storage is not reset; only the pointers and count define validity
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= ext_data;
  end
  // Pointers wrap naturally; count tracks occupancy independent of pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
  // Head byte falls through; zero when nothing is buffered
  always_comb begin
    cpu_data  = w_empty ? 8'h00 : r_mem[r_rp];
    cpu_empty = w_empty;
    ext_full  = w_full;
    cpu_count = r_count;
  end
`ifdef IO_IN_OVF_EN
  logic r_ovf;
  // Sticky drop flag; a new drop beats a clear in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ovf <= 1'b0;
    else r_ovf <= w_drop ? 1'b1 : (ovf_clr ? 1'b0 : r_ovf);
  end
  assign ovf = r_ovf;
`else
  logic w_unused;
  assign w_unused = ^{ovf_clr, w_drop};
  assign ovf = 1'b0;
`endif
endmodule
